// File: rtl/instr_dispatch_scheduler.sv
// Instruction dispatch scheduler: pops one instruction from the FIFO head,
// decodes its class and issues it to the weight, matrix-multiply or
// activation controller once the target and its data dependencies are free.
// Also handles NOP/HALT and counts dependency stall cycles.

package instr_dispatch_scheduler_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  flags;
        logic [15:0] operand;
    } instr_type;
endpackage

module instr_dispatch_scheduler
    import instr_dispatch_scheduler_pkg::*;
#(
    parameter int unsigned STALL_CTR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  instr_type                  instr_in,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    output instr_type                  instr_out,
    output logic                       weight_instr_enable,
    output logic                       mmu_instr_enable,
    output logic                       act_instr_enable,
    input  logic                       weight_busy,
    input  logic                       weight_resource_busy,
    input  logic                       mmu_busy,
    input  logic                       mmu_resource_busy,
    input  logic                       act_busy,
    input  logic                       act_resource_busy,
    input  logic                       resume,
    output logic                       halted,
    output logic                       busy,
    output logic [STALL_CTR_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_HALT_DRAIN,
        S_HALTED
    } state_e;

    typedef enum logic [2:0] {
        C_NOP,
        C_HALT,
        C_WEIGHT,
        C_MATMUL,
        C_ACT
    } class_e;

    state_e                     state_q, state_d;
    instr_type                  instr_q, instr_d;
    logic [STALL_CTR_WIDTH-1:0] stall_q, stall_d;
    class_e                     cls;
    logic                       ready_c;
    logic                       w_fire, m_fire, a_fire;
    logic                       go;

    // Outputs are suppressed while frozen or held in reset.
    assign go = enable && !rst;

    // Decode the captured opcode in priority order.
    always_comb begin
        cls = C_NOP;
        if (instr_q.opcode == 8'hFF)
            cls = C_HALT;
        else if (instr_q.opcode == 8'h00)
            cls = C_NOP;
        else if (instr_q.opcode[7:3] == 5'b00001)
            cls = C_WEIGHT;
        else if (instr_q.opcode[7:5] == 3'b001)
            cls = C_MATMUL;
        else if (instr_q.opcode[7])
            cls = C_ACT;
        else
            cls = C_NOP;
    end

    // Next-state, capture, dispatch and stall-count logic.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        stall_d = stall_q;
        ready_c = 1'b0;
        w_fire  = 1'b0;
        m_fire  = 1'b0;
        a_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    instr_d = instr_in;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                case (cls)
                    C_HALT:   state_d = S_HALT_DRAIN;
                    C_WEIGHT: w_fire = !weight_busy;
                    C_MATMUL: m_fire = !mmu_busy && !weight_resource_busy;
                    C_ACT:    a_fire = !act_busy && !mmu_resource_busy;
                    default:  state_d = S_IDLE;
                endcase
                if (w_fire || m_fire || a_fire) begin
                    state_d = S_IDLE;
                end else if ((cls == C_WEIGHT || cls == C_MATMUL || cls == C_ACT)
                             && stall_q != '1) begin
                    stall_d = stall_q + STALL_CTR_WIDTH'(1);
                end
            end
            S_HALT_DRAIN: begin
                if (!weight_resource_busy && !mmu_resource_busy && !act_resource_busy)
                    state_d = S_HALTED;
            end
            S_HALTED: begin
                if (resume)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wins over enable, enable=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            stall_q <= '0;
        end else if (enable) begin
            state_q <= state_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    assign instr_ready         = ready_c && go;
    assign weight_instr_enable = w_fire && go;
    assign mmu_instr_enable    = m_fire && go;
    assign act_instr_enable    = a_fire && go;
    assign instr_out           = instr_q;
    assign stall_count         = stall_q;
    assign halted              = (state_q == S_HALTED);
    assign busy                = (state_q != S_IDLE) || weight_resource_busy
                                 || mmu_resource_busy || act_resource_busy;

endmodule
